// File: rtl/nrzi_rx_deserializer.sv
// rtl/nrzi_rx_deserializer.sv - NRZI receive decoder with SYNC hunt, bit unstuffing and word assembly
// Optional feature macro: NRZI_RX_BITCOUNT_EN adds the rx_bit_count output.
module nrzi_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int STUFF_LEN  = 6,
  parameter int SYNC_ZEROS = 7
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  pulse,
  input  logic                  start_decoding,
  input  logic                  curr_encoded_bit,
  input  logic                  se0,
  output logic                  decoded_bit,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  eop,
  output logic                  stuff_err,
  output logic                  align_err,
`ifdef NRZI_RX_BITCOUNT_EN
  output logic [15:0]           rx_bit_count,
`endif
  output logic                  active
);

  typedef enum logic [1:0] {IDLE, HUNT, DATA, ERR} state_t;

  localparam logic [3:0] SYNC_Z   = 4'(SYNC_ZEROS);
  localparam logic [3:0] STUFF_L  = 4'(STUFF_LEN);
  localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic                  prev_q, prev_d;
  logic [3:0]            zero_cnt_q, zero_cnt_d;
  logic [3:0]            ones_cnt_q, ones_cnt_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  eop_q, eop_d;
  logic                  stuff_err_q, stuff_err_d;
  logic                  align_err_q, align_err_d;
  logic                  bit_accept;
  logic                  enter_data;

  assign decoded_bit = ~(curr_encoded_bit ^ prev_q);

  // Next-state, counter, shift and strobe logic; bits only act on pulse cycles
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    zero_cnt_d   = zero_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    eop_d        = 1'b0;
    stuff_err_d  = 1'b0;
    align_err_d  = 1'b0;
    bit_accept   = 1'b0;
    if (!start_decoding) begin
      state_d = IDLE;
    end else begin
      if (pulse) prev_d = curr_encoded_bit;
      case (state_q)
        IDLE: state_d = HUNT;
        HUNT: begin
          if (pulse) begin
            if (se0) begin
              state_d = IDLE;
            end else if (decoded_bit) begin
              if (zero_cnt_q >= SYNC_Z) begin
                state_d    = DATA;
                ones_cnt_d = 4'd0;
                bit_cnt_d  = 5'd0;
                shift_d    = '0;
              end
              zero_cnt_d = 4'd0;
            end else if (zero_cnt_q != 4'hF) begin
              zero_cnt_d = zero_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (pulse) begin
            if (se0) begin
              eop_d       = 1'b1;
              align_err_d = (bit_cnt_q != 5'd0);
              state_d     = IDLE;
            end else if (ones_cnt_q == STUFF_L) begin
              if (decoded_bit) begin
                stuff_err_d = 1'b1;
                state_d     = ERR;
              end else begin
                ones_cnt_d = 4'd0;
              end
            end else begin
              bit_accept = 1'b1;
              shift_d    = {decoded_bit, shift_q[DATA_WIDTH-1:1]};
              ones_cnt_d = decoded_bit ? ones_cnt_q + 4'd1 : 4'd0;
              if (bit_cnt_q == LAST_BIT) begin
                data_out_d   = shift_d;
                data_valid_d = 1'b1;
                bit_cnt_d    = 5'd0;
              end else begin
                bit_cnt_d = bit_cnt_q + 5'd1;
              end
            end
          end
        end
        ERR: begin
          if (pulse && se0) begin
            eop_d   = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Any return to IDLE restores the idle-J reference and drops partial state
    if (state_d == IDLE && state_q != IDLE) begin
      prev_d     = 1'b1;
      zero_cnt_d = 4'd0;
      ones_cnt_d = 4'd0;
      bit_cnt_d  = 5'd0;
      shift_d    = '0;
    end
  end

  assign enter_data = (state_q != DATA) && (state_d == DATA);

  // State and datapath registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      prev_q       <= 1'b1;
      zero_cnt_q   <= 4'd0;
      ones_cnt_q   <= 4'd0;
      bit_cnt_q    <= 5'd0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      eop_q        <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      zero_cnt_q   <= zero_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      eop_q        <= eop_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
    end
  end

`ifdef NRZI_RX_BITCOUNT_EN
  logic [15:0] bit_count_q, bit_count_d;

  // Packet data-bit counter: cleared at SYNC, saturating, held after eop
  always_comb begin
    bit_count_d = bit_count_q;
    if (enter_data) bit_count_d = 16'd0;
    else if (bit_accept && bit_count_q != 16'hFFFF) bit_count_d = bit_count_q + 16'd1;
  end

  // Bit counter register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) bit_count_q <= 16'd0;
    else       bit_count_q <= bit_count_d;
  end

  assign rx_bit_count = bit_count_q;
`else
  logic unused_count_inputs;
  assign unused_count_inputs = bit_accept ^ enter_data;
`endif

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign eop        = eop_q;
  assign stuff_err  = stuff_err_q;
  assign align_err  = align_err_q;
  assign active     = (state_q == DATA);

endmodule
